// File: rtl/csr_file_if.sv
// CSR access port: index, masked write strobe and combinational read data.
interface csr_file_if;
    logic [13:0] csr_addr;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;

    modport master (output csr_addr, csr_we, csr_wmask, csr_wdata, input csr_rdata);
    modport slave  (input csr_addr, csr_we, csr_wmask, csr_wdata, output csr_rdata);
endinterface

// File: rtl/csr_file.sv
// Privileged CSR file: mode/exception state, interrupt status, scratch registers
// and a down-counting timer with one-shot or periodic reload.
module csr_file #(
    parameter int         SAVE_NUM = 4,
    parameter int         TIMER_W  = 32,
    parameter int         HWI_NUM  = 8,
    parameter logic [8:0] COREID   = 9'h0
) (
    input  logic               clk,
    input  logic               rstn,
    csr_file_if.slave          csr,
    input  logic               ex_en,
    input  logic               ertn_en,
    input  logic [5:0]         ecode,
    input  logic [8:0]         esubcode,
    input  logic [31:0]        ex_pc,
    input  logic [31:0]        ex_vaddr,
    input  logic               badv_we,
    input  logic [HWI_NUM-1:0] hw_int,
    input  logic               ipi,
    output logic               int_req,
    output logic [31:0]        ex_entry,
    output logic [31:0]        era_out,
    output logic [1:0]         plv_out
);
    localparam logic [13:0] ADDR_CRMD   = 14'h00;
    localparam logic [13:0] ADDR_PRMD   = 14'h01;
    localparam logic [13:0] ADDR_ECFG   = 14'h04;
    localparam logic [13:0] ADDR_ESTAT  = 14'h05;
    localparam logic [13:0] ADDR_ERA    = 14'h06;
    localparam logic [13:0] ADDR_BADV   = 14'h07;
    localparam logic [13:0] ADDR_EENTRY = 14'h0C;
    localparam logic [13:0] ADDR_CPUID  = 14'h20;
    localparam logic [13:0] ADDR_SAVE0  = 14'h30;
    localparam logic [13:0] ADDR_TID    = 14'h40;
    localparam logic [13:0] ADDR_TCFG   = 14'h41;
    localparam logic [13:0] ADDR_TVAL   = 14'h42;
    localparam logic [13:0] ADDR_TICLR  = 14'h44;

    localparam logic [31:0] CRMD_WMASK   = 32'h0000_01FF;
    localparam logic [31:0] PRMD_WMASK   = 32'h0000_0007;
    localparam logic [31:0] ECFG_WMASK   = 32'h0000_1BFF;
    localparam logic [31:0] ESTAT_WMASK  = 32'h0000_0003;
    localparam logic [31:0] EENTRY_WMASK = 32'hFFFF_FFC0;
    localparam logic [12:0] INT_MASK     = 13'h1BFF;

    logic [31:0]        crmd_q, crmd_d, prmd_q, prmd_d, ecfg_q, ecfg_d, estat_q, estat_d;
    logic [31:0]        era_q, era_d, badv_q, badv_d, eentry_q, eentry_d, tid_q, tid_d;
    logic [31:0]        save_q [SAVE_NUM];
    logic [31:0]        save_d [SAVE_NUM];
    logic [TIMER_W-1:0] tcfg_q, tcfg_d, tval_q, tval_d;
    logic [31:0]        tcfg_new;
    logic [7:0]         hwi_vec;
    logic               tcfg_wr, ticlr, timer_fire;

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] writable,
                                          input logic [31:0] wmask, input logic [31:0] wdata);
        logic [31:0] en;
        en    = wmask & writable;
        merge = (old_v & ~en) | (wdata & en);
    endfunction

    // NOTE: every variable gets its hold value first so no path can infer a latch.
    always_comb begin
        crmd_d   = crmd_q;
        prmd_d   = prmd_q;
        ecfg_d   = ecfg_q;
        estat_d  = estat_q;
        era_d    = era_q;
        badv_d   = badv_q;
        eentry_d = eentry_q;
        tid_d    = tid_q;
        save_d   = save_q;
        tcfg_d   = tcfg_q;
        tval_d   = tval_q;
        tcfg_new = 32'h0;
        tcfg_wr  = 1'b0;
        ticlr    = 1'b0;
        timer_fire = 1'b0;
        hwi_vec  = 8'h0;
        hwi_vec[HWI_NUM-1:0] = hw_int;

        if (csr.csr_we) begin
            unique case (csr.csr_addr)
                ADDR_CRMD:   crmd_d   = merge(crmd_q, CRMD_WMASK, csr.csr_wmask, csr.csr_wdata);
                ADDR_PRMD:   prmd_d   = merge(prmd_q, PRMD_WMASK, csr.csr_wmask, csr.csr_wdata);
                ADDR_ECFG:   ecfg_d   = merge(ecfg_q, ECFG_WMASK, csr.csr_wmask, csr.csr_wdata);
                ADDR_ESTAT:  estat_d  = merge(estat_q, ESTAT_WMASK, csr.csr_wmask, csr.csr_wdata);
                ADDR_ERA:    era_d    = merge(era_q, '1, csr.csr_wmask, csr.csr_wdata);
                ADDR_BADV:   badv_d   = merge(badv_q, '1, csr.csr_wmask, csr.csr_wdata);
                ADDR_EENTRY: eentry_d = merge(eentry_q, EENTRY_WMASK, csr.csr_wmask, csr.csr_wdata);
                ADDR_TID:    tid_d    = merge(tid_q, '1, csr.csr_wmask, csr.csr_wdata);
                ADDR_TCFG: begin
                    tcfg_wr  = 1'b1;
                    tcfg_new = merge(32'(tcfg_q), '1, csr.csr_wmask, csr.csr_wdata);
                    tcfg_d   = tcfg_new[TIMER_W-1:0];
                end
                ADDR_TICLR:  ticlr    = csr.csr_wmask[0] & csr.csr_wdata[0];
                default: ;
            endcase
            for (int i = 0; i < SAVE_NUM; i++) begin
                if (csr.csr_addr == ADDR_SAVE0 + 14'(i))
                    save_d[i] = merge(save_q[i], '1, csr.csr_wmask, csr.csr_wdata);
            end
        end

        // Later assignments override the CSR write on shared fields: ex_en > ertn_en > csr_we.
        if (ertn_en) crmd_d[2:0] = prmd_q[2:0];
        if (ex_en) begin
            prmd_d[2:0]    = crmd_q[2:0];
            crmd_d[2:0]    = 3'b000;
            estat_d[21:16] = ecode;
            estat_d[30:22] = esubcode;
            era_d          = ex_pc;
            if (badv_we) badv_d = ex_vaddr;
        end

        if (tcfg_wr) begin
            if (tcfg_d[0]) tval_d = {tcfg_d[TIMER_W-1:2], 2'b00};
        end else if (tcfg_q[0]) begin
            if (tval_q > TIMER_W'(1)) begin
                tval_d = tval_q - TIMER_W'(1);
            end else if (tval_q == TIMER_W'(1)) begin
                timer_fire = 1'b1;
                tval_d     = tcfg_q[1] ? {tcfg_q[TIMER_W-1:2], 2'b00} : '0;
            end
        end

        estat_d[9:2] = hwi_vec;
        estat_d[12]  = ipi;
        estat_d[11]  = timer_fire | (estat_q[11] & ~ticlr);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            crmd_q   <= 32'h0000_0008;
            prmd_q   <= '0;
            ecfg_q   <= '0;
            estat_q  <= '0;
            era_q    <= '0;
            badv_q   <= '0;
            eentry_q <= '0;
            tid_q    <= '0;
            tcfg_q   <= '0;
            tval_q   <= '0;
            // NOTE: the scratch array is architecturally visible after reset, so it is reset too.
            for (int i = 0; i < SAVE_NUM; i++) save_q[i] <= '0;
        end else begin
            crmd_q   <= crmd_d;
            prmd_q   <= prmd_d;
            ecfg_q   <= ecfg_d;
            estat_q  <= estat_d;
            era_q    <= era_d;
            badv_q   <= badv_d;
            eentry_q <= eentry_d;
            tid_q    <= tid_d;
            tcfg_q   <= tcfg_d;
            tval_q   <= tval_d;
            save_q   <= save_d;
        end
    end

    always_comb begin
        csr.csr_rdata = 32'h0;
        unique case (csr.csr_addr)
            ADDR_CRMD:   csr.csr_rdata = crmd_q;
            ADDR_PRMD:   csr.csr_rdata = prmd_q;
            ADDR_ECFG:   csr.csr_rdata = ecfg_q;
            ADDR_ESTAT:  csr.csr_rdata = estat_q;
            ADDR_ERA:    csr.csr_rdata = era_q;
            ADDR_BADV:   csr.csr_rdata = badv_q;
            ADDR_EENTRY: csr.csr_rdata = eentry_q;
            ADDR_CPUID:  csr.csr_rdata = {23'h0, COREID};
            ADDR_TID:    csr.csr_rdata = tid_q;
            ADDR_TCFG:   csr.csr_rdata = 32'(tcfg_q);
            ADDR_TVAL:   csr.csr_rdata = 32'(tval_q);
            default: ;
        endcase
        for (int i = 0; i < SAVE_NUM; i++) begin
            if (csr.csr_addr == ADDR_SAVE0 + 14'(i)) csr.csr_rdata = save_q[i];
        end
    end

    assign int_req  = crmd_q[2] & |(estat_q[12:0] & ecfg_q[12:0] & INT_MASK);
    assign ex_entry = eentry_q;
    assign era_out  = era_q;
    assign plv_out  = crmd_q[1:0];
endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: table of masked write/readback vectors plus
// hand-written exception, timer, interrupt and reset sequences.
module tb_csr_file;
    logic        clk;
    logic        rstn;
    logic        ex_en, ertn_en, badv_we, ipi;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic [31:0] ex_pc, ex_vaddr;
    logic [3:0]  hw_int;
    logic        int_req;
    logic [31:0] ex_entry, era_out;
    logic [1:0]  plv_out;
    int          checks, failures;

    csr_file_if bus ();

    csr_file #(.SAVE_NUM(2), .TIMER_W(32), .HWI_NUM(4), .COREID(9'h5)) dut (
        .clk(clk), .rstn(rstn), .csr(bus),
        .ex_en(ex_en), .ertn_en(ertn_en), .ecode(ecode), .esubcode(esubcode),
        .ex_pc(ex_pc), .ex_vaddr(ex_vaddr), .badv_we(badv_we),
        .hw_int(hw_int), .ipi(ipi),
        .int_req(int_req), .ex_entry(ex_entry), .era_out(era_out), .plv_out(plv_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [13:0] addr;
        logic [31:0] wmask;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [13:0] addr, output logic [31:0] v);
        bus.csr_addr = addr;
        #1;
        v = bus.csr_rdata;
    endtask

    task automatic check_rd(input string name, input logic [13:0] addr, input logic [31:0] exp);
        logic [31:0] v;
        rd(addr, v);
        check(name, v, exp);
    endtask

    task automatic wr(input logic [13:0] addr, input logic [31:0] mask, input logic [31:0] data);
        bus.csr_addr  = addr;
        bus.csr_wmask = mask;
        bus.csr_wdata = data;
        bus.csr_we    = 1'b1;
        step(1);
        bus.csr_we    = 1'b0;
    endtask

    task automatic check_ti(input string name, input logic exp);
        logic [31:0] v;
        rd(14'h05, v);
        check(name, {31'b0, v[11]}, {31'b0, exp});
    endtask

    task automatic check_int(input string name, input logic exp);
        check(name, {31'b0, int_req}, {31'b0, exp});
    endtask

    vec_t vecs [22];

    initial begin
        logic [31:0] v;
        checks = 0;
        failures = 0;
        rstn = 1'b0;
        ex_en = 1'b0; ertn_en = 1'b0; badv_we = 1'b0; ipi = 1'b0;
        ecode = '0; esubcode = '0; ex_pc = '0; ex_vaddr = '0; hw_int = '0;
        bus.csr_addr = '0; bus.csr_we = 1'b0; bus.csr_wmask = '0; bus.csr_wdata = '0;

        vecs[0]  = '{"crmd_wr",      14'h00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_01FF};
        vecs[1]  = '{"prmd_wr",      14'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0007};
        vecs[2]  = '{"ecfg_wr",      14'h04, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_1BFF};
        vecs[3]  = '{"estat_wr",     14'h05, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0003};
        vecs[4]  = '{"era_wr",       14'h06, 32'hFFFF_FFFF, 32'h1234_5678, 32'h1234_5678};
        vecs[5]  = '{"badv_wr",      14'h07, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[6]  = '{"eentry_wr",    14'h0C, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFC0};
        vecs[7]  = '{"cpuid_ro",     14'h20, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0005};
        vecs[8]  = '{"save0_wr",     14'h30, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 32'hAAAA_AAAA};
        vecs[9]  = '{"save0_mask",   14'h30, 32'h0000_00FF, 32'h5555_5555, 32'hAAAA_AA55};
        vecs[10] = '{"save1_wr",     14'h31, 32'hFFFF_FFFF, 32'h0BAD_F00D, 32'h0BAD_F00D};
        vecs[11] = '{"save2_absent", 14'h32, 32'hFFFF_FFFF, 32'h1111_1111, 32'h0000_0000};
        vecs[12] = '{"tid_wr",       14'h40, 32'hFFFF_FFFF, 32'hCAFE_0001, 32'hCAFE_0001};
        vecs[13] = '{"tcfg_noen",    14'h41, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
        vecs[14] = '{"tval_ro",      14'h42, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[15] = '{"tcfg_clr",     14'h41, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
        vecs[16] = '{"ticlr_rd0",    14'h44, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        vecs[17] = '{"unmapped",     14'h99, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[18] = '{"estat_clr",    14'h05, 32'h0000_0003, 32'h0000_0000, 32'h0000_0000};
        vecs[19] = '{"ecfg_clr",     14'h04, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
        vecs[20] = '{"crmd_plvclr",  14'h00, 32'h0000_0003, 32'h0000_0000, 32'h0000_01FC};
        vecs[21] = '{"crmd_restore", 14'h00, 32'hFFFF_FFFF, 32'h0000_0008, 32'h0000_0008};

        step(2);
        rstn = 1'b1;

        // Reset state.
        check_rd("rst_crmd", 14'h00, 32'h0000_0008);
        check_rd("rst_cpuid", 14'h20, 32'h0000_0005);
        check_rd("rst_unmapped", 14'h99, 32'h0);
        check_rd("rst_save0", 14'h30, 32'h0);
        check_int("rst_int_req", 1'b0);
        check("rst_ex_entry", ex_entry, 32'h0);
        check("rst_era_out", era_out, 32'h0);
        check("rst_plv_out", {30'b0, plv_out}, 32'h0);

        foreach (vecs[i]) begin
            wr(vecs[i].addr, vecs[i].wmask, vecs[i].wdata);
            check_rd(vecs[i].name, vecs[i].addr, vecs[i].exp);
        end
        check("ex_entry_out", ex_entry, 32'hFFFF_FFC0);

        // Exception entry and return.
        wr(14'h00, 32'hFFFF_FFFF, 32'h0000_0007);
        wr(14'h01, 32'hFFFF_FFFF, 32'h0000_0000);
        check("plv_before_ex", {30'b0, plv_out}, 32'h3);
        ex_en = 1'b1; ecode = 6'hB; esubcode = 9'h0; ex_pc = 32'h1C00_0100; ex_vaddr = 32'h1111_2222;
        step(1);
        ex_en = 1'b0;
        check_rd("ex_crmd", 14'h00, 32'h0);
        check_rd("ex_prmd", 14'h01, 32'h7);
        check_rd("ex_estat", 14'h05, 32'h000B_0000);
        check_rd("ex_era", 14'h06, 32'h1C00_0100);
        check_rd("ex_badv_kept", 14'h07, 32'hDEAD_BEEF);
        check("ex_era_out", era_out, 32'h1C00_0100);
        ertn_en = 1'b1;
        step(1);
        ertn_en = 1'b0;
        check_rd("ertn_crmd", 14'h00, 32'h7);
        check_rd("ertn_prmd", 14'h01, 32'h7);
        check("ertn_plv_out", {30'b0, plv_out}, 32'h3);

        // ex_en beats ertn_en and a CSR write to ERA in the same cycle.
        wr(14'h01, 32'hFFFF_FFFF, 32'h0000_0000);
        ex_en = 1'b1; ertn_en = 1'b1; badv_we = 1'b1;
        ecode = 6'h3F; esubcode = 9'h1FF; ex_pc = 32'h2000_0040; ex_vaddr = 32'h0000_BEEF;
        wr(14'h06, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        ex_en = 1'b0; ertn_en = 1'b0; badv_we = 1'b0;
        check_rd("prio_era", 14'h06, 32'h2000_0040);
        check_rd("prio_badv", 14'h07, 32'h0000_BEEF);
        check_rd("prio_crmd", 14'h00, 32'h0);
        check_rd("prio_prmd", 14'h01, 32'h7);
        rd(14'h05, v);
        check("prio_estat_cause", {17'b0, v[30:16]}, 32'h0000_7FFF);
        ertn_en = 1'b1;
        step(1);
        ertn_en = 1'b0;
        check_rd("prio_ertn_crmd", 14'h00, 32'h7);

        // One-shot timer: INITVAL=2 -> TVAL=8.
        wr(14'h41, 32'hFFFF_FFFF, 32'h0000_0009);
        check_rd("os_load", 14'h42, 32'd8);
        step(7);
        check_rd("os_tval1", 14'h42, 32'd1);
        check_ti("os_ti_early", 1'b0);
        step(1);
        check_rd("os_tval0", 14'h42, 32'd0);
        check_ti("os_ti_set", 1'b1);
        step(5);
        check_rd("os_tval_hold", 14'h42, 32'd0);
        wr(14'h44, 32'h1, 32'h1);
        check_ti("os_ticlr", 1'b0);
        step(3);
        check_ti("os_ti_once", 1'b0);

        // Periodic timer with the timer interrupt enabled.
        wr(14'h04, 32'hFFFF_FFFF, 32'h0000_0800);
        wr(14'h41, 32'hFFFF_FFFF, 32'h0000_000B);
        check_rd("per_load", 14'h42, 32'd8);
        step(7);
        check_rd("per_tval1", 14'h42, 32'd1);
        check_int("per_int_idle", 1'b0);
        step(1);
        check_rd("per_reload", 14'h42, 32'd8);
        check_ti("per_ti_set", 1'b1);
        check_int("per_int_req", 1'b1);
        wr(14'h44, 32'h1, 32'h1);
        check_rd("per_tval7", 14'h42, 32'd7);
        check_int("per_int_clr", 1'b0);
        step(6);
        check_rd("per_tval1_b", 14'h42, 32'd1);
        check_ti("per_ti_clear", 1'b0);
        step(1);
        check_ti("per_ti_period", 1'b1);
        check_rd("per_reload_b", 14'h42, 32'd8);
        wr(14'h44, 32'h1, 32'h1);
        step(6);
        check_rd("coinc_tval1", 14'h42, 32'd1);
        wr(14'h44, 32'h1, 32'h1);
        check_ti("coinc_ti_wins", 1'b1);
        check_int("coinc_int_req", 1'b1);
        wr(14'h41, 32'hFFFF_FFFF, 32'h0000_0000);
        step(3);
        check_rd("freeze_tval", 14'h42, 32'd8);

        // Hardware interrupt and IPI sampling.
        wr(14'h44, 32'h1, 32'h1);
        hw_int = 4'b0001;
        rd(14'h05, v);
        check("hwi_no_bypass", {31'b0, v[2]}, 32'h0);
        step(1);
        rd(14'h05, v);
        check("hwi0_sampled", {31'b0, v[2]}, 32'h1);
        hw_int = 4'hF; ipi = 1'b1;
        step(1);
        rd(14'h05, v);
        check("hwi_low", {28'b0, v[5:2]}, 32'hF);
        check("hwi_unused", {28'b0, v[9:6]}, 32'h0);
        check("ipi_sampled", {31'b0, v[12]}, 32'h1);
        hw_int = 4'h0; ipi = 1'b0;
        step(1);
        rd(14'h05, v);
        check("hwi_released", {19'b0, v[12:0]}, 32'h0);

        // Reset while a write and an exception are requested.
        rstn = 1'b0;
        ex_en = 1'b1; ex_pc = 32'h3333_4444;
        wr(14'h06, 32'hFFFF_FFFF, 32'h5555_6666);
        rstn = 1'b1; ex_en = 1'b0;
        check_rd("rst2_crmd", 14'h00, 32'h0000_0008);
        check_rd("rst2_prmd", 14'h01, 32'h0);
        check_rd("rst2_era", 14'h06, 32'h0);
        check_rd("rst2_save0", 14'h30, 32'h0);
        check_rd("rst2_tval", 14'h42, 32'h0);
        check_rd("rst2_estat", 14'h05, 32'h0);
        check("rst2_ex_entry", ex_entry, 32'h0);
        check_int("rst2_int_req", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
